// File: rtl/miriscv_loader_pkg.sv
// miriscv_loader_pkg
//   Shared definitions for the boot loader: FSM state encoding and the
//   width of the image length prefix.
package miriscv_loader_pkg;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        DONE,
        ERROR
    } loader_state_e;

    localparam int unsigned LEN_W = 16;

endpackage

// File: rtl/miriscv_loader_packer.sv
// miriscv_loader_packer
//   Collects four accepted bytes into one 32-bit word.
//   Ports:
//     clk        - system clock
//     rst        - synchronous active-high clear of byte index and partial word
//     octet      - incoming byte
//     accept     - octet is taken this cycle
//     word       - assembled word, valid while word_valid is high
//     word_valid - high in the cycle the 4th byte of a word is accepted
//   SWAP_BYTES = 1 places the first byte in the MSB ({b0,b1,b2,b3}),
//   SWAP_BYTES = 0 places it in the LSB ({b3,b2,b1,b0}).
module miriscv_loader_packer #(
    parameter bit SWAP_BYTES = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  octet,
    input  logic        accept,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0] bidx;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;

    always_ff @(posedge clk) begin
        if (rst) begin
            bidx <= '0;
            b0   <= '0;
            b1   <= '0;
            b2   <= '0;
        end else if (accept) begin
            case (bidx)
                2'd0:    b0 <= octet;
                2'd1:    b1 <= octet;
                2'd2:    b2 <= octet;
                default: ;
            endcase
            bidx <= bidx + 2'd1;
        end
    end

    // The 4th byte is not stored; it is combined directly so the caller can
    // register the full word on the same edge that accepts it.
    always_comb begin
        word_valid = accept && (bidx == 2'd3);
        if (SWAP_BYTES)
            word = {b0, b1, b2, octet};
        else
            word = {octet, b2, b1, b0};
    end

endmodule

// File: rtl/miriscv_boot_loader.sv
// miriscv_boot_loader
//   Receives a length-prefixed program image (16-bit little-endian word count
//   followed by the words as bytes), writes the words sequentially into RAM
//   and holds the core in reset until the whole image has been written.
//   Ports:
//     clk_i, rst_i  - clock, synchronous active-high reset
//     byte_i        - image byte
//     byte_valid_i  - byte_i valid
//     byte_ready_o  - loader accepts a byte this cycle
//     mem_we_o      - RAM write strobe, one cycle per word
//     mem_addr_o    - RAM word address
//     mem_wdata_o   - RAM write data
//     core_rst_o    - active-high core reset, released after the last write
//     done_o        - image loaded, core released
//     err_o         - image length exceeded RAM_SIZE
module miriscv_boot_loader
    import miriscv_loader_pkg::*;
#(
    parameter int unsigned RAM_SIZE   = 512,
    parameter bit          SWAP_BYTES = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [7:0]                  byte_i,
    input  logic                        byte_valid_i,
    output logic                        byte_ready_o,
    output logic                        mem_we_o,
    output logic [$clog2(RAM_SIZE)-1:0] mem_addr_o,
    output logic [31:0]                 mem_wdata_o,
    output logic                        core_rst_o,
    output logic                        done_o,
    output logic                        err_o
);

    localparam int unsigned      AW         = $clog2(RAM_SIZE);
    localparam int unsigned      WW         = AW + 1;
    localparam logic [LEN_W:0]   RAM_SIZE_L = RAM_SIZE[LEN_W:0];
    localparam logic [LEN_W-1:0] LEN_ONE    = 1;
    localparam logic [WW-1:0]    WIDX_ONE   = 1;

    loader_state_e    state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_full;
    logic [LEN_W-1:0] last_idx;
    logic [LEN_W-1:0] widx_ext;
    logic [WW-1:0]    widx;
    logic             accept;
    logic             pack_accept;
    logic             word_valid;
    logic [31:0]      word;

    assign accept      = byte_valid_i && byte_ready_o;
    assign pack_accept = accept && (state == DATA);
    assign len_full    = {byte_i, len[7:0]};
    assign last_idx    = len - LEN_ONE;
    assign widx_ext    = {{(LEN_W-WW){1'b0}}, widx};

    miriscv_loader_packer #(
        .SWAP_BYTES (SWAP_BYTES)
    ) u_packer (
        .clk        (clk_i),
        .rst        (rst_i),
        .octet      (byte_i),
        .accept     (pack_accept),
        .word       (word),
        .word_valid (word_valid)
    );

    // done_o/core_rst_o/err_o follow the state one edge late, so the release
    // lands on the edge after the final write strobe rather than alongside it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= LEN_LO;
            len          <= '0;
            widx         <= '0;
            byte_ready_o <= 1'b1;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            core_rst_o   <= 1'b1;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            mem_we_o   <= 1'b0;
            done_o     <= (state == DONE);
            core_rst_o <= (state != DONE);
            err_o      <= (state == ERROR);

            case (state)
                LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= byte_i;
                        state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len[LEN_W-1:8] <= byte_i;
                        if (len_full == '0) begin
                            state        <= DONE;
                            byte_ready_o <= 1'b0;
                        end else if ({1'b0, len_full} > RAM_SIZE_L) begin
                            state        <= ERROR;
                            byte_ready_o <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_valid) begin
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= widx[AW-1:0];
                        mem_wdata_o <= word;
                        widx        <= widx + WIDX_ONE;
                        if (widx_ext == last_idx) begin
                            state        <= DONE;
                            byte_ready_o <= 1'b0;
                        end
                    end
                end
                DONE, ERROR: begin
                    byte_ready_o <= 1'b0;
                end
                default: begin
                    state <= LEN_LO;
                end
            endcase
        end
    end

endmodule

// File: doc/miriscv_boot_loader.md
# miriscv_boot_loader

Byte-stream program loader sitting directly upstream of `miriscv_top`. It receives a length-prefixed program image over a valid/ready byte interface, assembles bytes into 32-bit words, writes them sequentially into the instruction/data RAM through a dedicated write port, and holds the core in reset until the image is complete. It replaces back-door RAM pokes with a synthesizable boot path.

## Interface
- `RAM_SIZE`, 512: RAM depth in 32-bit words; images longer than this are rejected.
- `SWAP_BYTES`, 1: 1 writes words byte-reversed (`{b0,b1,b2,b3}`) to match the RAM storage order; 0 writes little-endian (`{b3,b2,b1,b0}`).
- `clk_i` in 1: system clock; single clock domain.
- `rst_i` in 1: reset; synchronous, active-high.
- `byte_i` in 8: incoming image byte.
- `byte_valid_i` in 1: `byte_i` valid.
- `byte_ready_o` out 1: loader accepts the byte this cycle.
- `mem_we_o` out 1: RAM write strobe, one cycle per word.
- `mem_addr_o` out $clog2(RAM_SIZE): RAM word address.
- `mem_wdata_o` out 32: RAM write data.
- `core_rst_o` out 1: active-high reset for the core; high until load completes.
- `done_o` out 1: image loaded, core released.
- `err_o` out 1: image length exceeds `RAM_SIZE`.

## Operation
- A byte is accepted on a rising edge where `byte_valid_i && byte_ready_o`.
- FSM states:
  - LEN_LO: accept a byte and latch it as `len[7:0]`, then go to LEN_HI.
  - LEN_HI: accept a byte and latch it as `len[15:8]`.
    - If `len == 0`, go to DONE.
    - If `len > RAM_SIZE`, go to ERROR.
    - Otherwise go to DATA.
  - DATA: accept bytes into the 2-bit byte index `bidx`. When the 4th byte is accepted:
    - Present the word and pulse `mem_we_o` on the next cycle at address `widx`.
    - Increment `widx`.
    - After the write of word `len-1`, go to DONE.
  - DONE: terminal. `byte_ready_o` is 0; bytes are ignored.
  - ERROR: terminal. `byte_ready_o` is 0; `core_rst_o` is 1; `err_o` is 1.
- `byte_ready_o` is 1 in LEN_LO, LEN_HI and DATA. Back-to-back bytes are accepted every cycle.
- The word write happens while byte 0 of the next word is being accepted; no stall.
- `widx` is `$clog2(RAM_SIZE)+1` bits and never wraps, because the length is checked beforehand.
- Only `rst_i` leaves DONE or ERROR. `rst_i` mid-load aborts the load:
  - `bidx`, `widx` and the partial word are cleared.
  - RAM contents already written stay as written.

## Timing
- Values on `rst_i`, applied at the next edge:
  - state = LEN_LO; `byte_ready_o` = 1; `mem_we_o` = 0; `mem_addr_o` = 0; `mem_wdata_o` = 0.
  - `core_rst_o` = 1; `done_o` = 0; `err_o` = 0.
- Write latency: `mem_we_o` is high exactly one cycle after the edge that accepted the 4th byte of a word.
  - `mem_addr_o` and `mem_wdata_o` are registered and valid in the same cycle.
  - `mem_addr_o` and `mem_wdata_o` hold their values when `mem_we_o` is 0.
- Release timing: `done_o` rises and `core_rst_o` falls on the edge after the final `mem_we_o` cycle. The core therefore never sees reset deasserted while a write is in flight.
- Zero-length image: `done_o` rises and `core_rst_o` falls on the edge after the LEN_HI byte is accepted.
- ERROR: `err_o` rises on the edge after the LEN_HI byte is accepted.
- Valid gaps: `byte_valid_i` low stalls the FSM with all state held; there is no timeout.

## Structure
- Package `miriscv_loader_pkg`:
  - `loader_state_e` enum: LEN_LO, LEN_HI, DATA, DONE, ERROR.
  - `LEN_W = 16` constant.
- Sub-module `miriscv_loader_packer`:
  - Function: shift-in of 4 bytes with byte-swap selection.
  - Inputs: byte, accept.
  - Outputs: `word`, `word_valid` pulse.
- `miriscv_boot_loader` contains the FSM, counters and output registers.
- Intended integration: `miriscv_top` takes `core_rst_o` (inverted to its `rst_n_i`), and the RAM write port is muxed with the core's store port while `core_rst_o` = 1.

## Test plan
- Single ADDI word:
  - Stimulus: `SWAP_BYTES=1`, bytes `01 00 93 00 D0 03` streamed back-to-back.
  - Required response: one `mem_we_o` pulse, addr 0, data `0x9300D003`; `done_o`=1 and `core_rst_o`=0 one cycle later.
- Three words with random `byte_valid_i` gaps, `SWAP_BYTES=0`:
  - Required response: writes to addrs 0,1,2 with correct LE words in order.
  - No `mem_we_o` before the 4th byte of each word.
- Zero length:
  - Stimulus: `00 00`.
  - Required response: no writes; `done_o`=1 on the next edge.
  - Further valid bytes: `byte_ready_o`=0 and nothing is written.
- Oversize length:
  - Stimulus: length `0x0201` with `RAM_SIZE=512`.
  - Required response: `err_o`=1, `core_rst_o` stays 1, no writes, `byte_ready_o`=0.
- Reset mid-word:
  - Stimulus: after `02 00 AA BB`, assert `rst_i` for 1 cycle, then send `01 00 11 22 33 44`.
  - Required response: one write to addr 0 with data `0x11223344`; all outputs at reset values during `rst_i`.
- Max length:
  - Stimulus: length 512 with a ramp pattern.
  - Required response: 512 writes at addrs 0..511 with no missed bytes at full rate; then `done_o`=1.
